vga_ctrl: RTL and testbench
===========================

// Module: vga_ctrl
// PURPOSE
//   640x480@60Hz VGA timing generator; sits downstream of the colour stage (VGA_jpg), 25 MHz pixel clock.
//   Sends pixel coordinates (jpg_x/jpg_y) to the colour stage DATA_LEAD cycles ahead of display,
//   to absorb that stage's registered latency.
//   Returns colour as rgb, with hsync/vsync to the DAC/connector.
// PARAMETERS
//   H_SYNC    10'd96   hsync pulse width, clocks; line counter 0 = first sync clock
//   H_BACK    10'd48   horizontal back porch
//   H_VALID   10'd640  active pixels per line
//   H_FRONT   10'd16   horizontal front porch (H_TOTAL = sum = 800)
//   V_SYNC    10'd2    vsync pulse width, lines; frame line 0 = first sync line
//   V_BACK    10'd33   vertical back porch
//   V_VALID   10'd480  active lines per frame
//   V_FRONT   10'd10   vertical front porch (V_TOTAL = sum = 525)
//   DATA_LEAD 2'd1     clocks that pix_req/jpg_x lead rgb_valid; legal 0..2
// PORTS
//   Clk_int     in   1   pixel clock, 25 MHz
//   Sys_Rst_n   in   1   reset, asynchronous, active-low
//   jpg_colour  in   16  RGB565 from colour stage; must match coordinates issued DATA_LEAD clocks earlier
//   jpg_x       out  10  requested pixel X, 0..H_VALID-1; 10'h3FF when pix_req=0
//   jpg_y       out  10  requested pixel Y, 0..V_VALID-1; 10'h3FF when pix_req=0
//   pix_req     out  1   jpg_x/jpg_y are a valid request this clock
//   rgb_valid   out  1   current clock is inside the active display area
//   rgb         out  16  jpg_colour when rgb_valid=1, else 16'h0000
//   hsync       out  1   active-low horizontal sync
//   vsync       out  1   active-low vertical sync
//   frame_start out  1   one-clock pulse at cnt_h=0 and cnt_v=0
// BEHAVIOUR
//   - Registers: cnt_h and cnt_v, both 10 bit. Every output is combinational decode of them plus jpg_colour.
//   - Reset: cnt_h=0, cnt_v=0.
//     While reset is held: hsync=0, vsync=0, frame_start=1, rgb_valid=0, pix_req=0, rgb=0,
//     jpg_x=jpg_y=10'h3FF.
//   - cnt_h increments every clock; wraps H_TOTAL-1 -> 0.
//   - cnt_v increments only on the clock where cnt_h=H_TOTAL-1; wraps V_TOTAL-1 -> 0.
//     Both wraps occur on the same edge at the end of a frame.
//   - hsync=0 iff cnt_h < H_SYNC. vsync=0 iff cnt_v < V_SYNC. vsync is not gated by cnt_h.
//   - HS = H_SYNC+H_BACK (144); VS = V_SYNC+V_BACK (35).
//   - rgb_valid = (HS <= cnt_h < HS+H_VALID) && (VS <= cnt_v < VS+V_VALID).
//   - pix_req = (HS-DATA_LEAD <= cnt_h < HS+H_VALID-DATA_LEAD) && (VS <= cnt_v < VS+V_VALID).
//     Its horizontal window is always inside the current line; it never requests next-line pixels.
//   - jpg_x = cnt_h-(HS-DATA_LEAD); jpg_y = cnt_v-VS.
//     Compute in 10-bit unsigned; values are only exposed while pix_req=1, so no underflow is visible.
//   - Latency: coordinate (x,y) is requested at cnt_h=HS+x-DATA_LEAD and displayed at cnt_h=HS+x.
//     With DATA_LEAD=1 this matches a one-register colour stage.
//   - Asynchronous reset mid-frame: counters return to 0 immediately.
//     The first post-reset frame is full length; no partial-frame recovery logic.
//   - jpg_colour is sampled by nothing internal; it passes to rgb gated by rgb_valid only.
// TESTING
//   1 Reset held 10 clks -> hsync=0, vsync=0, rgb=0, pix_req=0, jpg_x=3FF; release -> cnt_h 0,1,2...
//   2 Line timing: hsync low for exactly 96 clks, period 800; first rgb_valid at cnt_h=144, last at 783.
//   3 Frame timing: vsync low for exactly 1600 clks (2 lines), period 420000;
//     frame_start pulses once per frame.
//   4 Lead: at cnt_v=35, cnt_h=143 -> pix_req=1, jpg_x=0, jpg_y=0, rgb_valid=0;
//     cnt_h=782 -> jpg_x=639; cnt_h=783 -> pix_req=0, rgb_valid=1.
//   5 Passthrough: jpg_colour=16'hF800 -> rgb=F800 in active area and 0 in all blanking, incl. lines 0-34, 515-524.
//   6 Assert Sys_Rst_n low at cnt_v=200, cnt_h=400 for 3 clks
//     -> outputs take reset values asynchronously; next frame_start 420000 clks after release.

Source files
------------

// File: rtl/vga_ctrl.sv
// 640x480@60Hz VGA timing generator: pixel/line counters with combinational
// decode of sync, active-area, early coordinate requests and colour gating.
module vga_ctrl #(
    parameter logic [9:0] H_SYNC    = 10'd96,
    parameter logic [9:0] H_BACK    = 10'd48,
    parameter logic [9:0] H_VALID   = 10'd640,
    parameter logic [9:0] H_FRONT   = 10'd16,
    parameter logic [9:0] V_SYNC    = 10'd2,
    parameter logic [9:0] V_BACK    = 10'd33,
    parameter logic [9:0] V_VALID   = 10'd480,
    parameter logic [9:0] V_FRONT   = 10'd10,
    parameter logic [1:0] DATA_LEAD = 2'd1
) (
    input  logic        Clk_int,
    input  logic        Sys_Rst_n,
    input  logic [15:0] jpg_colour,
    output logic [9:0]  jpg_x,
    output logic [9:0]  jpg_y,
    output logic        pix_req,
    output logic        rgb_valid,
    output logic [15:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam logic [9:0] H_TOTAL   = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam logic [9:0] V_TOTAL   = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam logic [9:0] HS        = H_SYNC + H_BACK;
    localparam logic [9:0] VS        = V_SYNC + V_BACK;
    localparam logic [9:0] LEAD      = {8'd0, DATA_LEAD};
    localparam logic [9:0] REQ_START = HS - LEAD;
    localparam logic [9:0] REQ_END   = HS + H_VALID - LEAD;

    logic [9:0] cnt_h;
    logic [9:0] cnt_v;
    logic       line_active;

    // NOTE: counters are state, so they use non-blocking assignments; the
    // reset is asynchronous so outputs drop to reset decode immediately.
    always_ff @(posedge Clk_int or negedge Sys_Rst_n) begin
        if (!Sys_Rst_n) begin
            cnt_h <= 10'd0;
            cnt_v <= 10'd0;
        end else if (cnt_h == H_TOTAL - 10'd1) begin
            cnt_h <= 10'd0;
            if (cnt_v == V_TOTAL - 10'd1)
                cnt_v <= 10'd0;
            else
                cnt_v <= cnt_v + 10'd1;
        end else begin
            cnt_h <= cnt_h + 10'd1;
        end
    end

    // NOTE: every output gets a default first, so no path leaves one unassigned.
    always_comb begin
        line_active = (cnt_v >= VS) && (cnt_v < VS + V_VALID);
        hsync       = !(cnt_h < H_SYNC);
        vsync       = !(cnt_v < V_SYNC);
        frame_start = (cnt_h == 10'd0) && (cnt_v == 10'd0);
        rgb_valid   = line_active && (cnt_h >= HS) && (cnt_h < HS + H_VALID);
        pix_req     = line_active && (cnt_h >= REQ_START) && (cnt_h < REQ_END);
        jpg_x       = 10'h3FF;
        jpg_y       = 10'h3FF;
        rgb         = 16'h0000;
        // Requests lead display by DATA_LEAD clocks to cover the colour stage latency.
        if (pix_req) begin
            jpg_x = cnt_h - REQ_START;
            jpg_y = cnt_v - VS;
        end
        if (rgb_valid)
            rgb = jpg_colour;
    end

endmodule

// File: tb/tb_vga_ctrl.sv
// Self-checking bench for vga_ctrl: a default-timing instance plus a short-frame,
// DATA_LEAD=2 instance, both compared every clock against a time-based model.
module tb_vga_ctrl;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        fs;
        logic        rv;
        logic        pr;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] rgb;
    } vga_out_t;

    localparam int SV_SYNC  = 2;
    localparam int SV_BACK  = 3;
    localparam int SV_VALID = 6;
    localparam int SV_FRONT = 2;
    localparam int S_FRAME  = 800 * (SV_SYNC + SV_BACK + SV_VALID + SV_FRONT);

    logic        Clk_int = 1'b0;
    logic        Sys_Rst_n;
    logic [15:0] jpg_colour;

    logic [9:0]  a_jpg_x, a_jpg_y, b_jpg_x, b_jpg_y;
    logic        a_pix_req, a_rgb_valid, a_hsync, a_vsync, a_frame_start;
    logic        b_pix_req, b_rgb_valid, b_hsync, b_vsync, b_frame_start;
    logic [15:0] a_rgb, b_rgb;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint t       = 0;
    longint cyc     = 0;
    logic   use_f800 = 1'b0;

    longint a_hfall = -1;
    longint b_vfall = -1;
    longint b_fs_last = -1;
    int     b_fs_count = 0;
    logic   a_hs_prev = 1'b0, b_vs_prev = 1'b0, b_fs_prev = 1'b0;

    always #20 Clk_int = ~Clk_int;

    vga_ctrl u_dut (
        .Clk_int(Clk_int), .Sys_Rst_n(Sys_Rst_n), .jpg_colour(jpg_colour),
        .jpg_x(a_jpg_x), .jpg_y(a_jpg_y), .pix_req(a_pix_req), .rgb_valid(a_rgb_valid),
        .rgb(a_rgb), .hsync(a_hsync), .vsync(a_vsync), .frame_start(a_frame_start)
    );

    vga_ctrl #(
        .V_SYNC(10'(SV_SYNC)), .V_BACK(10'(SV_BACK)), .V_VALID(10'(SV_VALID)),
        .V_FRONT(10'(SV_FRONT)), .DATA_LEAD(2'd2)
    ) u_small (
        .Clk_int(Clk_int), .Sys_Rst_n(Sys_Rst_n), .jpg_colour(jpg_colour),
        .jpg_x(b_jpg_x), .jpg_y(b_jpg_y), .pix_req(b_pix_req), .rgb_valid(b_rgb_valid),
        .rgb(b_rgb), .hsync(b_hsync), .vsync(b_vsync), .frame_start(b_frame_start)
    );

    // Expected outputs from elapsed clocks since reset release.
    function automatic vga_out_t model(input int hsy, input int hbk, input int hva, input int hfr,
                                       input int vsy, input int vbk, input int vva, input int vfr,
                                       input int lead, input longint tt, input logic [15:0] col);
        vga_out_t e;
        int h_tot = hsy + hbk + hva + hfr;
        int v_tot = vsy + vbk + vva + vfr;
        int h = int'(tt % longint'(h_tot));
        int v = int'((tt / longint'(h_tot)) % longint'(v_tot));
        int hs0 = hsy + hbk;
        int vs0 = vsy + vbk;
        logic in_v = (v >= vs0) && (v < vs0 + vva);
        e.hs  = (h >= hsy);
        e.vs  = (v >= vsy);
        e.fs  = (h == 0) && (v == 0);
        e.rv  = in_v && (h >= hs0) && (h < hs0 + hva);
        e.pr  = in_v && (h >= hs0 - lead) && (h < hs0 + hva - lead);
        e.x   = e.pr ? 10'(h - hs0 + lead) : 10'h3FF;
        e.y   = e.pr ? 10'(v - vs0) : 10'h3FF;
        e.rgb = e.rv ? col : 16'h0000;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp_v);
        end
    endtask

    task automatic compare();
        vga_out_t oa, ob, ea, eb;
        oa = {a_hsync, a_vsync, a_frame_start, a_rgb_valid, a_pix_req, a_jpg_x, a_jpg_y, a_rgb};
        ob = {b_hsync, b_vsync, b_frame_start, b_rgb_valid, b_pix_req, b_jpg_x, b_jpg_y, b_rgb};
        ea = model(96, 48, 640, 16, 2, 33, 480, 10, 1, t, jpg_colour);
        eb = model(96, 48, 640, 16, SV_SYNC, SV_BACK, SV_VALID, SV_FRONT, 2, t, jpg_colour);
        check("outputs_default", 64'(oa), 64'(ea));
        check("outputs_small", 64'(ob), 64'(eb));

        if (t == 28143)
            check("lead_first_req", 64'({a_pix_req, a_rgb_valid, a_jpg_x, a_jpg_y}),
                  64'({1'b1, 1'b0, 10'd0, 10'd0}));
        if (t == 28782)
            check("lead_last_req", 64'({a_pix_req, a_jpg_x}), 64'({1'b1, 10'd639}));
        if (t == 28783)
            check("lead_last_disp", 64'({a_pix_req, a_rgb_valid}), 64'({1'b0, 1'b1}));

        if (Sys_Rst_n) begin
            if (a_hs_prev && !a_hsync) begin
                if (a_hfall >= 0) check("hsync_period", 64'(cyc - a_hfall), 64'd800);
                a_hfall = cyc;
            end
            if (!a_hs_prev && a_hsync && a_hfall >= 0)
                check("hsync_low", 64'(cyc - a_hfall), 64'd96);
            if (b_vs_prev && !b_vsync) begin
                if (b_vfall >= 0) check("vsync_period", 64'(cyc - b_vfall), 64'(S_FRAME));
                b_vfall = cyc;
            end
            if (!b_vs_prev && b_vsync && b_vfall >= 0)
                check("vsync_low", 64'(cyc - b_vfall), 64'd1600);
            if (!b_fs_prev && b_frame_start) begin
                b_fs_count++;
                if (b_fs_last >= 0) check("frame_period", 64'(cyc - b_fs_last), 64'(S_FRAME));
                b_fs_last = cyc;
            end
        end else begin
            a_hfall   = -1;
            b_vfall   = -1;
            b_fs_last = -1;
        end
        a_hs_prev = a_hsync;
        b_vs_prev = b_vsync;
        b_fs_prev = b_frame_start;
    endtask

    task automatic step();
        @(posedge Clk_int);
        cyc++;
        if (Sys_Rst_n) t++;
        #1 jpg_colour = use_f800 ? 16'hF800 : 16'($urandom);
        @(negedge Clk_int);
        compare();
    endtask

    task automatic release_reset();
        Sys_Rst_n = 1'b1;
        t         = 0;
        a_hfall   = cyc;
        b_vfall   = cyc;
        b_fs_last = cyc;
    endtask

    initial begin
        jpg_colour = 16'h1234;
        Sys_Rst_n  = 1'b1;
        #5 Sys_Rst_n = 1'b0;
        for (int i = 0; i < 10; i++) step();
        release_reset();

        // Three short frames; the middle one carries constant red.
        for (int i = 0; i < 3 * S_FRAME && n_fail < 200; i++) begin
            use_f800 = (t >= S_FRAME - 1) && (t < 2 * S_FRAME - 1);
            step();
        end
        use_f800 = 1'b0;
        // Run into line 7 of the short frame, then reset mid-line at cnt_h=400.
        for (int i = 0; i < 7 * 800 + 400 && n_fail < 200; i++) step();
        check("frame_count_run", 64'(b_fs_count), 64'd3);

        #7 Sys_Rst_n = 1'b0;
        t = 0;
        #1 compare();
        for (int i = 0; i < 3; i++) step();
        release_reset();
        b_fs_count = 0;
        for (int i = 0; i < S_FRAME + 100 && n_fail < 200; i++) step();
        check("frame_count_after_reset", 64'(b_fs_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
